// File: rtl/pattern_encoder.sv
// Sparse-pattern encoder: row-major (row,col) pairs -> 16-bit delta tokens, 4 per 64-bit word, streamed to memory.
// Optional build macro PATTERN_ENCODER_COUNT_EN adds nnz_count and a trailer word after the end-of-stream word.
module pattern_encoder #(
    parameter int INDEX_WIDTH = 32,
    parameter int ADDR_WIDTH  = 48,
    parameter int OBUF_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic                   index_push,
    input  logic [INDEX_WIDTH-1:0] row,
    input  logic [INDEX_WIDTH-1:0] col,
    input  logic                   finish,
    output logic                   index_stall,
    output logic                   wr_req,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [63:0]            wr_data,
    input  logic                   wr_stall,
`ifdef PATTERN_ENCODER_COUNT_EN
    output logic [31:0]            nnz_count,
`endif
    output logic                   done,
    output logic                   err
);
    localparam int PW = $clog2(OBUF_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(OBUF_DEPTH);
    localparam logic [PW:0] THRESH   = (PW+1)'(OBUF_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
    state_t state, state_nx;

    logic [INDEX_WIDTH-1:0] cur_row;
    logic [INDEX_WIDTH:0]   base;
    logic [95:0]            seq_vec;
    logic [2:0]             seq_rem;
    logic                   seq_multi;
    logic [63:0]            pk_data;
    logic [2:0]             pk_cnt;
    logic [63:0]            fifo_mem [OBUF_DEPTH];
    logic [PW-1:0]          rd_ptr, wr_ptr;
    logic [PW:0]            fifo_cnt;
    logic [ADDR_WIDTH-1:0]  addr;

    // Token sequence for the pair on the inputs, relative to the current row/base.
    logic                   pair_bad;
    logic [INDEX_WIDTH-1:0] row_d;
    logic [INDEX_WIDTH:0]   base_eff, col_d;
    logic [32:0]            row_dx, col_dx;
    logic [31:0]            row32, col32;
    logic [47:0]            row_toks, col_toks;
    logic [2:0]             row_n, col_n, new_len;
    logic [95:0]            new_vec;

    always_comb begin
        row32    = 32'(row);
        col32    = 32'(col);
        row_d    = row - cur_row;
        row_dx   = 33'(row_d);
        pair_bad = (row < cur_row) || ((row == cur_row) && ({1'b0, col} < base));
        base_eff = (row == cur_row) ? base : '0;
        col_d    = {1'b0, col} - base_eff;
        col_dx   = 33'(col_d);
        row_toks = '0;
        row_n    = 3'd0;
        if (row != cur_row) begin
            if (row_dx > 33'd16383) begin
                row_toks = {row32[31:16], row32[15:0], 16'hE000};
                row_n    = 3'd3;
            end else begin
                row_toks = {32'h0, 2'b10, row_dx[13:0]};
                row_n    = 3'd1;
            end
        end
        if (col_dx > 33'd32767) begin
            col_toks = {col32[31:16], col32[15:0], 16'hC000};
            col_n    = 3'd3;
        end else begin
            col_toks = {32'h0, 1'b0, col_dx[14:0]};
            col_n    = 3'd1;
        end
        new_len = row_n + col_n;
        case (row_n)
            3'd0:    new_vec = {48'h0, col_toks};
            3'd1:    new_vec = {32'h0, col_toks, row_toks[15:0]};
            default: new_vec = {col_toks, row_toks};
        endcase
    end

    logic        fifo_full, pop, pk_full, pk_push, tok_go, seq_emit, flush_emit, tok_valid;
    logic        accept, fin, load, fifo_push, last_pop, trailer_ok, trailer_push;
    logic [15:0] tok;
    logic [1:0]  slot;
    logic [63:0] push_data;
`ifdef PATTERN_ENCODER_COUNT_EN
    logic        trailer_sent;
`endif

    always_comb begin
        fifo_full   = (fifo_cnt == FULL_CNT);
        wr_req      = (fifo_cnt != '0);
        pop         = wr_req && !wr_stall;
        pk_full     = (pk_cnt == 3'd4);
        pk_push     = pk_full && !fifo_full;
        tok_go      = !pk_full || pk_push;
        seq_emit    = (seq_rem != 3'd0) && tok_go;
        flush_emit  = (state == FLUSH) && (seq_rem == 3'd0) && tok_go;
        tok_valid   = seq_emit || flush_emit;
        tok         = seq_emit ? seq_vec[15:0] : 16'hFFFF;
        slot        = pk_full ? 2'd0 : pk_cnt[1:0];
        index_stall = (state != RUN) || ((seq_rem != 3'd0) && (seq_multi || !tok_go))
                      || (fifo_cnt >= THRESH);
        accept      = !index_stall && index_push;
        fin         = !index_stall && finish;
        load        = accept && !pair_bad;
`ifdef PATTERN_ENCODER_COUNT_EN
        trailer_ok   = trailer_sent;
        trailer_push = (state == DRAIN) && (pk_cnt == 3'd0) && !trailer_sent && !fifo_full;
        push_data    = pk_push ? pk_data : {32'h0, nnz_count};
`else
        trailer_ok   = 1'b1;
        trailer_push = 1'b0;
        push_data    = pk_data;
`endif
        fifo_push   = pk_push || trailer_push;
        last_pop    = (state == DRAIN) && (pk_cnt == 3'd0) && trailer_ok && (fifo_cnt == (PW+1)'(1))
                      && pop && !fifo_push;
        wr_addr     = addr;
        wr_data     = wr_req ? fifo_mem[rd_ptr] : '0;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (fin) state_nx = FLUSH;
            FLUSH:   if (flush_emit && (slot == 2'd3)) state_nx = DRAIN;
            DRAIN:   if (last_pop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_row   <= '0;
            base      <= '0;
            err       <= 1'b0;
            addr      <= '0;
            seq_rem   <= 3'd0;
            seq_multi <= 1'b0;
            pk_cnt    <= 3'd0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifo_cnt  <= '0;
            done      <= 1'b0;
`ifdef PATTERN_ENCODER_COUNT_EN
            nnz_count    <= 32'd0;
            trailer_sent <= 1'b0;
`endif
        end else begin
            done <= last_pop;
            if (state == IDLE && start) begin
                cur_row <= '0;
                base    <= '0;
                err     <= 1'b0;
                addr    <= start_addr;
`ifdef PATTERN_ENCODER_COUNT_EN
                nnz_count    <= 32'd0;
                trailer_sent <= 1'b0;
`endif
            end else begin
                if (pop) addr <= addr + ADDR_WIDTH'(1);
                if (accept && pair_bad) err <= 1'b1;
                if (load) begin
                    cur_row <= row;
                    base    <= {1'b0, col} + {{INDEX_WIDTH{1'b0}}, 1'b1};
`ifdef PATTERN_ENCODER_COUNT_EN
                    nnz_count <= nnz_count + 32'd1;
`endif
                end
`ifdef PATTERN_ENCODER_COUNT_EN
                if (trailer_push) trailer_sent <= 1'b1;
`endif
            end
            // A new pair may replace a sequence only while its single last token leaves.
            if (load) begin
                seq_rem   <= new_len;
                seq_multi <= (new_len > 3'd1);
            end else if (seq_emit) begin
                seq_rem <= seq_rem - 3'd1;
                if (seq_rem == 3'd1) seq_multi <= 1'b0;
            end
            if (tok_valid)    pk_cnt <= {1'b0, slot} + 3'd1;
            else if (pk_push) pk_cnt <= 3'd0;
            if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)       rd_ptr <= rd_ptr + PW'(1);
            case ({fifo_push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load)          seq_vec <= new_vec;
        else if (seq_emit) seq_vec <= {16'h0, seq_vec[95:16]};
        if (tok_valid) pk_data[{slot, 4'b0} +: 16] <= tok;
        if (fifo_push) fifo_mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_pattern_encoder.sv
// Scoreboard bench for pattern_encoder: expected writes queued by stimulus, checked by a write monitor.
`timescale 1ns/1ps
module tb_pattern_encoder;
    logic        clk = 1'b0;
    logic        rst, start, index_push, finish, wr_stall;
    logic [47:0] start_addr;
    logic [31:0] row, col;
    logic        index_stall, wr_req, done, err;
    logic [47:0] wr_addr;
    logic [63:0] wr_data;
`ifdef PATTERN_ENCODER_COUNT_EN
    logic [31:0] nnz_count;
`endif

    pattern_encoder #(.INDEX_WIDTH(32), .ADDR_WIDTH(48), .OBUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .index_push(index_push), .row(row), .col(col), .finish(finish),
        .index_stall(index_stall), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_stall(wr_stall),
`ifdef PATTERN_ENCODER_COUNT_EN
        .nnz_count(nnz_count),
`endif
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [111:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    always @(negedge clk) begin
        logic [111:0] e;
        if (rst && wr_req && !wr_stall) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e[111:64]));
                chk("wr_data", wr_data, e[63:0]);
            end
        end
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_word(input logic [47:0] a, input logic [63:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic exp_trailer(input logic [47:0] a, input logic [31:0] n);
`ifdef PATTERN_ENCODER_COUNT_EN
        exp_q.push_back({a, 32'h0, n});
`else
        if (n == 32'hFFFF_FFFF) $display("note: trailer %h %h", a, n);
`endif
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (index_stall && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) timeout_fail(name);
    endtask

    task automatic push(input logic [31:0] r, input logic [31:0] c);
        row = r;
        col = c;
        index_push = 1'b1;
        wait_ready("push_accept");
        step();
        index_push = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        wait_ready("finish_accept");
        step();
        finish = 1'b0;
    endtask

    task automatic do_start(input logic [47:0] a);
        start = 1'b1;
        start_addr = a;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) timeout_fail(name);
        else begin
            chk({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
            step();
            chk({name, "_done_pulse"}, 64'(done), 64'd0);
        end
    endtask

    task automatic stall_len(output int n);
        n = 0;
        while (index_stall && n < 50) begin
            n++;
            step();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] c;
        logic [47:0] sa;
        rst = 1'b0; start = 1'b0; start_addr = '0; index_push = 1'b0;
        row = '0; col = '0; finish = 1'b0; wr_stall = 1'b0;
        repeat (3) step();
        chk("rst_index_stall", 64'(index_stall), 64'd1);
        chk("rst_wr_req", 64'(wr_req), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b1;
        step();

        // Basic stream; a start pulse while running must be ignored.
        do_start(48'h100);
        exp_word(48'h100, 64'h0001_8002_0002_0000);
        exp_word(48'h101, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_trailer(48'h102, 32'd3);
        push(0, 0);
        start = 1'b1;
        start_addr = 48'h999;
        push(0, 3);
        start = 1'b0;
        push(2, 1);
        do_finish();
        wait_done("basic");
`ifdef PATTERN_ENCODER_COUNT_EN
        chk("nnz_count", 64'(nnz_count), 64'd3);
`endif

        // Column and row escapes.
        do_start(48'h180);
        exp_word(48'h180, 64'hE000_0000_9C40_C000);
        exp_word(48'h181, 64'hFFFF_0000_0000_4E20);
        exp_trailer(48'h182, 32'd2);
        push(0, 40000);
        stall_len(n);
        chk("col_escape_stall", 64'(n), 64'd3);
        push(20000, 0);
        stall_len(n);
        chk("row_escape_stall", 64'(n), 64'd4);
        do_finish();
        wait_done("escape");

        // Out-of-order pair is dropped and err sticks.
        do_start(48'h200);
        exp_word(48'h200, 64'h0001_8001_0007_8005);
        exp_word(48'h201, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_trailer(48'h202, 32'd2);
        push(5, 7);
        chk("err_before", 64'(err), 64'd0);
        push(5, 2);
        chk("err_set", 64'(err), 64'd1);
        push(6, 1);
        do_finish();
        wait_done("error");
        chk("err_sticky", 64'(err), 64'd1);

        // Backpressure across an address wrap.
        sa = 48'hFFFF_FFFF_FFFD;
        do_start(sa);
        chk("err_cleared", 64'(err), 64'd0);
        for (int k = 0; k < 7; k++)
            exp_word(sa + 48'(k), {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)});
        exp_word(sa + 48'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_trailer(sa + 48'd8, 32'd28);
        fork
            begin
                c = 0;
                for (int i = 0; i < 28; i++) begin
                    if (i != 0) c = c + 32'(i) + 32'd1;
                    push(0, c);
                end
                do_finish();
            end
            begin
                wr_stall = 1'b1;
                repeat (40) step();
                chk("thresh_index_stall", 64'(index_stall), 64'd1);
                chk("held_wr_req", 64'(wr_req), 64'd1);
                chk("held_wr_addr", 64'(wr_addr), 64'(sa));
                chk("held_wr_data", wr_data, 64'h0003_0002_0001_0000);
                wr_stall = 1'b0;
            end
        join
        wait_done("backpressure");

        // Reset mid-stream with a word waiting in the FIFO.
        do_start(48'h300);
        wr_stall = 1'b1;
        push(0, 0); push(0, 1); push(0, 3); push(0, 5); push(0, 7);
        repeat (3) step();
        chk("pre_reset_wr_req", 64'(wr_req), 64'd1);
        rst = 1'b0;
        #1;
        chk("reset_wr_req", 64'(wr_req), 64'd0);
        chk("reset_index_stall", 64'(index_stall), 64'd1);
        wr_stall = 1'b0;
        step();
        rst = 1'b1;
        repeat (3) step();

        // Pair and finish in the same cycle after reset.
        do_start(48'h400);
        exp_word(48'h400, 64'hFFFF_FFFF_0002_8001);
        exp_trailer(48'h401, 32'd1);
        row = 1;
        col = 2;
        index_push = 1'b1;
        finish = 1'b1;
        wait_ready("push_finish_accept");
        step();
        index_push = 1'b0;
        finish = 1'b0;
        wait_done("push_finish");
        chk("done_count", 64'(done_cnt), 64'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
